uart_rx_line_ctrl: RTL and testbench



---
 rtl/uart_rx_line_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_uart_rx_line_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_line_ctrl
// Brief    : Majority-filters the synchronized rx line on oversample ticks and
//            sequences idle / start-qualify / active / break line state.
//            Optional macro UART_GLITCH_CNT_EN enables the glitch counter.
// Revision : 1.0
// ============================================================================
module uart_rx_line_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int FILTER_LEN = 3,
    parameter int IDLE_BITS  = 2,
    parameter int BREAK_BITS = 11
) (
    input  logic       clk_dst,
    input  logic       rst_n_dst,
    input  logic       rx_sync,
    input  logic       baud_tick,
    input  logic       enable,
    output logic       rx_filt,
    output logic       line_idle,
    output logic       start_det,
    output logic       break_det,
    output logic       break_active,
    output logic       idle_det,
    output logic [7:0] glitch_count
);

    localparam int c_CNT_W = $clog2(BREAK_BITS * OVERSAMPLE + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = '1;
    localparam logic [c_CNT_W-1:0] c_IDLE_THR  = c_CNT_W'(IDLE_BITS * OVERSAMPLE);
    localparam logic [c_CNT_W-1:0] c_BREAK_THR = c_CNT_W'(BREAK_BITS * OVERSAMPLE);
    localparam logic [c_CNT_W-1:0] c_QUAL_THR  = c_CNT_W'(OVERSAMPLE / 2);

    localparam logic [1:0] c_ST_ACTIVE = 2'd0;
    localparam logic [1:0] c_ST_IDLE   = 2'd1;
    localparam logic [1:0] c_ST_QUAL   = 2'd2;
    localparam logic [1:0] c_ST_BREAK  = 2'd3;

    // Only FILTER_LEN-1 past samples are stored; the current rx_sync completes the window.
    logic [FILTER_LEN-2:0] r_win_hist;
    logic [FILTER_LEN-1:0] w_win;
    logic                  r_rx_filt;
    logic [c_CNT_W-1:0]    r_hi_cnt;
    logic [c_CNT_W-1:0]    r_lo_cnt;
    logic [c_CNT_W-1:0]    w_hi_next;
    logic [c_CNT_W-1:0]    w_lo_next;
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  w_start_ev;
    logic                  w_break_ev;
    logic                  w_idle_ev;
    logic                  r_line_idle;
    logic                  r_break_active;
    logic                  r_start_det;
    logic                  r_break_det;
    logic                  r_idle_det;

    function automatic logic majority(input logic [FILTER_LEN-1:0] win);
        int n;
        n = 0;
        for (int i = 0; i < FILTER_LEN; i++) begin
            if (win[i]) n++;
        end
        return (n > FILTER_LEN / 2);
    endfunction

    assign w_win = {r_win_hist, rx_sync};

    // State register: filter, run-length counters and line state
    always_ff @(posedge clk_dst or negedge rst_n_dst) begin
        if (!rst_n_dst) begin
            r_win_hist <= '1;
            r_rx_filt  <= 1'b1;
            r_hi_cnt   <= '0;
            r_lo_cnt   <= '0;
            r_state    <= c_ST_ACTIVE;
        end else begin
            if (baud_tick) begin
                r_win_hist <= w_win[FILTER_LEN-2:0];
                r_rx_filt  <= majority(w_win);
            end
            if (!enable) begin
                r_state  <= c_ST_ACTIVE;
                r_hi_cnt <= '0;
                r_lo_cnt <= '0;
            end else if (baud_tick) begin
                r_state  <= w_state_next;
                r_hi_cnt <= w_hi_next;
                r_lo_cnt <= w_lo_next;
            end
        end
    end

    // Next-state logic works on the one-tick-old filtered value
    always_comb begin
        w_hi_next    = '0;
        w_lo_next    = '0;
        w_state_next = r_state;
        if (r_rx_filt) begin
            w_hi_next = (r_hi_cnt == c_CNT_MAX) ? r_hi_cnt : r_hi_cnt + 1'b1;
        end else begin
            w_lo_next = (r_lo_cnt == c_CNT_MAX) ? r_lo_cnt : r_lo_cnt + 1'b1;
        end
        case (r_state)
            c_ST_ACTIVE: begin
                if (r_rx_filt && (w_hi_next >= c_IDLE_THR)) begin
                    w_state_next = c_ST_IDLE;
                end else if (!r_rx_filt && (w_lo_next >= c_BREAK_THR)) begin
                    w_state_next = c_ST_BREAK;
                end
            end
            c_ST_IDLE: begin
                if (!r_rx_filt) w_state_next = c_ST_QUAL;
            end
            c_ST_QUAL: begin
                if (r_rx_filt) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_lo_next >= c_QUAL_THR) begin
                    w_state_next = c_ST_ACTIVE;
                end
            end
            default: begin
                if (r_rx_filt) w_state_next = c_ST_ACTIVE;
            end
        endcase
    end

    // Output decode: event strobes from the transition being taken
    always_comb begin
        w_start_ev = 1'b0;
        w_break_ev = 1'b0;
        w_idle_ev  = 1'b0;
        if (r_state == c_ST_QUAL && w_state_next == c_ST_ACTIVE) w_start_ev = 1'b1;
        if (r_state == c_ST_ACTIVE && w_state_next == c_ST_BREAK) w_break_ev = 1'b1;
        if (r_state == c_ST_ACTIVE && w_state_next == c_ST_IDLE) w_idle_ev = 1'b1;
    end

    always_ff @(posedge clk_dst or negedge rst_n_dst) begin
        if (!rst_n_dst) begin
            r_line_idle    <= 1'b0;
            r_break_active <= 1'b0;
            r_start_det    <= 1'b0;
            r_break_det    <= 1'b0;
            r_idle_det     <= 1'b0;
        end else begin
            r_start_det <= 1'b0;
            r_break_det <= 1'b0;
            r_idle_det  <= 1'b0;
            if (!enable) begin
                r_line_idle    <= 1'b0;
                r_break_active <= 1'b0;
            end else if (baud_tick) begin
                r_start_det    <= w_start_ev;
                r_break_det    <= w_break_ev;
                r_idle_det     <= w_idle_ev;
                r_line_idle    <= (w_state_next == c_ST_IDLE);
                r_break_active <= (w_state_next == c_ST_BREAK);
            end
        end
    end

    assign rx_filt      = r_rx_filt;
    assign line_idle    = r_line_idle;
    assign break_active = r_break_active;
    assign start_det    = r_start_det;
    assign break_det    = r_break_det;
    assign idle_det     = r_idle_det;

`ifdef UART_GLITCH_CNT_EN
    logic       w_glitch_ev;
    logic [7:0] r_glitch_cnt;

    assign w_glitch_ev = (r_state == c_ST_QUAL) && (w_state_next == c_ST_IDLE);

    always_ff @(posedge clk_dst or negedge rst_n_dst) begin
        if (!rst_n_dst) begin
            r_glitch_cnt <= '0;
        end else if (enable && baud_tick && w_glitch_ev && (r_glitch_cnt != 8'hFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 8'd1;
        end
    end

    assign glitch_count = r_glitch_cnt;
`else
    assign glitch_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_line_ctrl
// Brief    : Randomized scenario bench for uart_rx_line_ctrl against a
//            run-length based line model; baud_tick every 4 cycles.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_line_ctrl;

    localparam int OS = 16;
    localparam int FL = 3;
    localparam int IDLE_T  = 2 * OS;
    localparam int BREAK_T = 11 * OS;
    localparam int QUAL_T  = OS / 2;

    logic       clk_dst = 1'b0;
    logic       rst_n_dst = 1'b0;
    logic       rx_sync = 1'b1;
    logic       baud_tick = 1'b0;
    logic       enable = 1'b1;
    logic       rx_filt;
    logic       line_idle;
    logic       start_det;
    logic       break_det;
    logic       break_active;
    logic       idle_det;
    logic [7:0] glitch_count;

    uart_rx_line_ctrl #(
        .OVERSAMPLE (OS),
        .FILTER_LEN (FL),
        .IDLE_BITS  (2),
        .BREAK_BITS (11)
    ) u_dut (
        .clk_dst      (clk_dst),
        .rst_n_dst    (rst_n_dst),
        .rx_sync      (rx_sync),
        .baud_tick    (baud_tick),
        .enable       (enable),
        .rx_filt      (rx_filt),
        .line_idle    (line_idle),
        .start_det    (start_det),
        .break_det    (break_det),
        .break_active (break_active),
        .idle_det     (idle_det),
        .glitch_count (glitch_count)
    );

    always #5 clk_dst = ~clk_dst;

    int checks = 0;
    int failures = 0;

    typedef enum int {M_ACTIVE, M_IDLE, M_QUAL, M_BREAK} mstate_t;
    mstate_t m_state;
    logic    m_hist[$];
    logic    m_filt;
    logic    m_run_val;
    int      m_run_len;
    int      m_glitch;
    logic    m_start, m_brk, m_idle;

    logic [14:0] obs_vec;
    int n_start, n_brk, n_idle;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < FL; i++) m_hist.push_back(1'b1);
        m_state = M_ACTIVE; m_filt = 1'b1; m_run_val = 1'b1; m_run_len = 0;
        m_glitch = 0; m_start = 0; m_brk = 0; m_idle = 0;
    endtask

    // Line model: FSM reacts to how long the previous filtered value has persisted
    task automatic model_tick(input logic rx, input logic en);
        logic old;
        int ones;
        old = m_filt;
        m_hist.push_back(rx);
        void'(m_hist.pop_front());
        ones = 0;
        foreach (m_hist[i]) if (m_hist[i]) ones++;
        m_filt = (2 * ones > FL);
        m_start = 0; m_brk = 0; m_idle = 0;
        if (!en) begin
            m_state = M_ACTIVE;
            m_run_len = 0;
        end else begin
            if (m_run_len == 0 || old != m_run_val) begin
                m_run_val = old;
                m_run_len = 1;
            end else if (m_run_len < 255) begin
                m_run_len++;
            end
            case (m_state)
                M_ACTIVE: if (old && m_run_len >= IDLE_T) begin m_state = M_IDLE; m_idle = 1; end
                          else if (!old && m_run_len >= BREAK_T) begin m_state = M_BREAK; m_brk = 1; end
                M_IDLE:   if (!old) m_state = M_QUAL;
                M_QUAL:   if (old) begin m_state = M_IDLE; if (m_glitch < 255) m_glitch++; end
                          else if (m_run_len >= QUAL_T) begin m_state = M_ACTIVE; m_start = 1; end
                default:  if (old) m_state = M_ACTIVE;
            endcase
        end
    endtask

    function automatic logic [14:0] exp_vec();
        logic [7:0] g;
`ifdef UART_GLITCH_CNT_EN
        g = 8'(m_glitch);
`else
        g = 8'd0;
`endif
        return {1'b0, m_filt, (m_state == M_IDLE), (m_state == M_BREAK), m_start, m_brk, m_idle, g};
    endfunction

    // One oversample tick followed by three quiet cycles; bit 14 flags a pulse in the quiet cycles
    task automatic tick(input logic rx, input logic en);
        logic gap;
        gap = 1'b0;
        rx_sync = rx; enable = en; baud_tick = 1'b1;
        @(posedge clk_dst); #1;
        baud_tick = 1'b0;
        model_tick(rx, en);
        obs_vec[13:0] = {rx_filt, line_idle, break_active, start_det, break_det, idle_det, glitch_count};
        n_start += int'(start_det); n_brk += int'(break_det); n_idle += int'(idle_det);
        repeat (3) begin
            @(posedge clk_dst); #1;
            if (start_det || break_det || idle_det) gap = 1'b1;
        end
        obs_vec[14] = gap;
    endtask

    task automatic clear_counts();
        n_start = 0; n_brk = 0; n_idle = 0;
    endtask

    task automatic test_reset();
        rst_n_dst = 1'b0;
        repeat (3) @(posedge clk_dst);
        #1;
        checks++;
        if ({rx_filt, line_idle, break_active, start_det, break_det, idle_det, glitch_count} !== 14'h2000) begin
            failures++;
            $display("FAIL reset_values: got %h want %h",
                     {rx_filt, line_idle, break_active, start_det, break_det, idle_det, glitch_count}, 14'h2000);
        end
        rst_n_dst = 1'b1;
        model_reset();
    endtask

    task automatic test_idle_qual();
        int n;
        clear_counts();
        n = $urandom_range(36, 44);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL idle_qual tick %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        checks++;
        if (n_idle != 1 || n_start != 0 || line_idle !== 1'b1) begin
            failures++;
            $display("FAIL idle_qual_pulses: got idle=%0d start=%0d line_idle=%b want 1 0 1", n_idle, n_start, line_idle);
        end
    endtask

    task automatic test_start();
        int n;
        clear_counts();
        n = $urandom_range(12, 30);
        for (int i = 0; i < n + 36; i++) begin
            tick((i < n) ? 1'b0 : 1'b1, 1'b1);
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL start tick %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        checks++;
        if (n_start != 1 || n_idle != 1) begin
            failures++;
            $display("FAIL start_pulses: got start=%0d idle=%0d want 1 1", n_start, n_idle);
        end
    endtask

    task automatic test_glitch();
        int k;
        clear_counts();
        k = $urandom_range(2, 7);
        for (int i = 0; i < 4 + k + 10; i++) begin
            tick((i == 0 || (i >= 4 && i < 4 + k)) ? 1'b0 : 1'b1, 1'b1);
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL glitch tick %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        checks++;
        if (n_start != 0 || line_idle !== 1'b1) begin
            failures++;
            $display("FAIL glitch_abort: got start=%0d line_idle=%b want 0 1", n_start, line_idle);
        end
    endtask

    task automatic test_break();
        int n;
        clear_counts();
        n = $urandom_range(180, 220);
        for (int i = 0; i < n + 40; i++) begin
            tick((i < n) ? 1'b0 : 1'b1, 1'b1);
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL break tick %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        checks++;
        if (n_start != 1 || n_brk != 1 || n_idle != 1) begin
            failures++;
            $display("FAIL break_pulses: got start=%0d break=%0d idle=%0d want 1 1 1", n_start, n_brk, n_idle);
        end
    endtask

    task automatic test_requalify();
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
        #2;
        rst_n_dst = 1'b0;
        #1;
        checks++;
        if ({rx_filt, line_idle, break_active, start_det, break_det, idle_det, glitch_count} !== 14'h2000) begin
            failures++;
            $display("FAIL async_reset: got %h want %h",
                     {rx_filt, line_idle, break_active, start_det, break_det, idle_det, glitch_count}, 14'h2000);
        end
        @(posedge clk_dst); #1;
        rst_n_dst = 1'b1;
        model_reset();
        clear_counts();
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 36; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL requalify tick %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
        checks++;
        if (n_start != 0 || n_idle != 1) begin
            failures++;
            $display("FAIL requalify_pulses: got start=%0d idle=%0d want 0 1", n_start, n_idle);
        end
        for (int i = 0; i < 36; i++) tick(1'b1, 1'b1);
    endtask

    task automatic test_no_tick();
        logic [14:0] e;
        e = exp_vec();
        baud_tick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rx_sync = 1'($urandom_range(0, 1));
            @(posedge clk_dst); #1;
            checks++;
            if ({rx_filt, line_idle, break_active, start_det, break_det, idle_det, glitch_count} !== {e[13:11], 3'b000, e[7:0]}) begin
                failures++;
                $display("FAIL no_tick cycle %0d: got %h want %h", i,
                         {rx_filt, line_idle, break_active, start_det, break_det, idle_det, glitch_count},
                         {e[13:11], 3'b000, e[7:0]});
            end
        end
    endtask

    task automatic test_random();
        logic cur;
        logic en;
        cur = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) cur = ~cur;
            en = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            tick(($urandom_range(0, 29) == 0) ? ~cur : cur, en);
            checks++;
            if (obs_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random tick %0d: got %h want %h", i, obs_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_qual();
        test_start();
        test_glitch();
        test_glitch();
        test_break();
        test_requalify();
        test_no_tick();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
